// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and helpers for the bit-serial subtraction controller.
// The FSM state encoding and the bit-counter width are used by the controller.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the bit counter; a minimum of one bit keeps degenerate widths legal.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Start/done request bus between a requester and the serial subtractor.
// The master drives the operands and start; the slave returns flags and results.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, zero
    );
endinterface

// File: rtl/serial_sub_ctrl_fullsub.sv
// Combinational full-subtractor cell assembled from two half-subtractors.
// d = x - y - bin (one bit); bout is the borrow out of that bit.
module halfsub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bout
);
    assign d    = x ^ y;
    assign bout = ~x & y;
endmodule

module fullsub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d_first;
    logic b_first;
    logic b_second;

    halfsub u_hs_xy (
        .x    (x),
        .y    (y),
        .d    (d_first),
        .bout (b_first)
    );

    // Second stage subtracts the incoming borrow from the partial difference.
    halfsub u_hs_bin (
        .x    (d_first),
        .y    (bin),
        .d    (d),
        .bout (b_second)
    );

    assign bout = b_first | b_second;
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: one fullsub cell, LSB first, one bit per clock.
// Results load on the last shift edge and hold until the next completed operation.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg;
    state_t           state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-2:0] diff_sr_reg;
    logic             bin_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             zero_reg;

    logic             d_bit;
    logic             bout_bit;
    logic             last_bit;
    logic [WIDTH-1:0] diff_shifted;

    fullsub u_fullsub (
        .x    (a_sr_reg[0]),
        .y    (b_sr_reg[0]),
        .bin  (bin_reg),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // The partial difference is kept one bit short: the newest bit completes it.
    assign diff_shifted = {d_bit, diff_sr_reg};
    assign last_bit     = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            a_sr_reg    <= '0;
            b_sr_reg    <= '0;
            diff_sr_reg <= '0;
            bin_reg     <= 1'b0;
            diff_reg    <= '0;
            borrow_reg  <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_sr_reg    <= bus.a;
                        b_sr_reg    <= bus.b;
                        diff_sr_reg <= '0;
                        bin_reg     <= 1'b0;
                        cnt_reg     <= '0;
                    end
                end
                SHIFT: begin
                    a_sr_reg    <= a_sr_reg >> 1;
                    b_sr_reg    <= b_sr_reg >> 1;
                    diff_sr_reg <= diff_shifted[WIDTH-1:1];
                    bin_reg     <= bout_bit;
                    cnt_reg     <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        diff_reg   <= diff_shifted;
                        borrow_reg <= bout_bit;
                        zero_reg   <= (diff_shifted == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_reg == SHIFT);
    assign bus.done   = (state_reg == DONE);
    assign bus.diff   = diff_reg;
    assign bus.borrow = borrow_reg;
    assign bus.zero   = zero_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases plus random
// operands, checked against plain modular subtraction.
module tb_serial_sub_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_quiet(input string tag, input int cycles);
        bit quiet = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) quiet = 1'b0;
        end
        check_val(tag, 32'(quiet), 32'd1);
    endtask

    // Called at a sample point with the DUT idle; returns one cycle after done.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input bit noise);
        logic [7:0] exp_diff;
        logic       exp_borrow;
        logic       exp_zero;
        int         busy_cnt;
        bit         seen;
        bit         overlap;
        exp_diff   = op_a - op_b;
        exp_borrow = (op_a < op_b);
        exp_zero   = (op_a == op_b);
        bus.start = 1'b1;
        bus.a     = op_a;
        bus.b     = op_b;
        tick();
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        busy_cnt = 0;
        seen     = 1'b0;
        overlap  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
            if (bus.done === 1'b1) seen = 1'b1;
            else if (bus.busy === 1'b1) busy_cnt++;
            if (noise && i == 2) begin
                bus.start = 1'b1;
                bus.a     = 8'($urandom);
                bus.b     = 8'($urandom);
            end else if (noise && i == 3) begin
                bus.start = 1'b0;
            end
            if (!seen) tick();
        end
        if (!seen) begin
            check_val("done_timeout", 32'd0, 32'd1);
            return;
        end
        check_val("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        check_val("busy_done_overlap", 32'(overlap), 32'd0);
        check_val("diff", 32'(bus.diff), 32'(exp_diff));
        check_val("borrow", 32'(bus.borrow), 32'(exp_borrow));
        check_val("zero", 32'(bus.zero), 32'(exp_zero));
        $display("TXN a=0x%02h b=0x%02h diff=0x%02h borrow=%0b zero=%0b busy_cycles=%0d noise=%0b",
                 op_a, op_b, bus.diff, bus.borrow, bus.zero, busy_cnt, noise);
        if (noise) begin
            bus.start = 1'b1;
            bus.a     = 8'($urandom);
            bus.b     = 8'($urandom);
        end
        tick();
        bus.start = 1'b0;
        check_val("done_width", 32'(bus.done), 32'd0);
        if (noise) begin
            idle_quiet("no_queued_start", 3);
            check_val("diff_after_noise", 32'(bus.diff), 32'(exp_diff));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         stable;
        int         done_cnt;
        int         last_done;
        logic [7:0] cur_a;
        logic [7:0] cur_b;
        logic [7:0] ra;
        logic [7:0] rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset asserted between clock edges must clear outputs immediately.
        #2 rst_n = 1'b0;
        #1;
        check_val("reset_outputs", 32'({bus.busy, bus.done, bus.borrow, bus.zero, bus.diff}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        idle_quiet("no_done_without_start", 5);

        run_op(8'd5, 8'd3, 1'b0);
        run_op(8'd3, 8'd5, 1'b0);
        run_op(8'd0, 8'd1, 1'b0);
        run_op(8'hFF, 8'h00, 1'b0);
        run_op(8'h80, 8'h80, 1'b0);

        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.diff !== 8'h00 || bus.borrow !== 1'b0 || bus.zero !== 1'b1 ||
                bus.done !== 1'b0 || bus.busy !== 1'b0) stable = 1'b0;
        end
        check_val("result_hold_20", 32'(stable), 32'd1);

        run_op(8'h5A, 8'h3C, 1'b1);
        run_op(8'h10, 8'h20, 1'b1);

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = (i % 5 == 0) ? ra : 8'($urandom);
            run_op(ra, rb, ($urandom_range(0, 3) == 0));
        end

        // Holding start high: one result every WIDTH+2 cycles, operands picked up
        // on the accept edge that follows each done cycle.
        cur_a = 8'($urandom);
        cur_b = 8'($urandom);
        bus.a = cur_a;
        bus.b = cur_b;
        bus.start = 1'b1;
        done_cnt  = 0;
        last_done = -1;
        for (int cyc = 0; cyc < 80 && done_cnt < 4; cyc++) begin
            tick();
            if (bus.done === 1'b1) begin
                check_val("b2b_diff", 32'(bus.diff), 32'(8'(cur_a - cur_b)));
                check_val("b2b_borrow", 32'(bus.borrow), 32'(cur_a < cur_b));
                if (last_done >= 0) check_val("b2b_period", 32'(cyc - last_done), 32'(WIDTH + 2));
                $display("TXN b2b a=0x%02h b=0x%02h diff=0x%02h borrow=%0b cycle=%0d",
                         cur_a, cur_b, bus.diff, bus.borrow, cyc);
                last_done = cyc;
                done_cnt++;
                cur_a = 8'($urandom);
                cur_b = 8'($urandom);
                bus.a = cur_a;
                bus.b = cur_b;
                if (done_cnt == 4) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check_val("b2b_done_count", 32'(done_cnt), 32'd4);
        idle_quiet("b2b_drain", 3);

        // Reset four edges into an operation: aborted, results cleared.
        run_op(8'd9, 8'd2, 1'b0);
        bus.start = 1'b1;
        bus.a     = 8'h44;
        bus.b     = 8'h11;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check_val("midop_reset_outputs", 32'({bus.busy, bus.done, bus.borrow, bus.zero, bus.diff}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        idle_quiet("midop_no_done", 12);
        check_val("midop_diff_cleared", 32'(bus.diff), 32'd0);
        run_op(8'h37, 8'h12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
